// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: ALU/branch op codes, divider state encodings and helpers for the execute stage.
package ex_stage_pkg;
  localparam int ALU_OP_WIDTH = 5;
  localparam int BRANCH_WIDTH = 2;
  typedef enum logic [ALU_OP_WIDTH-1:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU, OP_SLL,
    OP_SRL, OP_SRA, OP_LUI, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO
  } alu_op_e;
  typedef enum logic [BRANCH_WIDTH-1:0] {BR_NONE, BR_EQ, BR_NE, BR_J} br_type_e;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;
  function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
    return (s && x[31]) ? -x : x;
  endfunction
endpackage

// File: rtl/ex_divider.sv
// ex_divider: unsigned restoring divider, one quotient bit per cycle; quot_o/rem_o are the next-step values.
module ex_divider
  import ex_stage_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         last_o,
  output logic         done_o,
  output logic [W-1:0] quot_o,
  output logic [W-1:0] rem_o
);
  localparam int CW = $clog2(W);
  div_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0] quot_q, rem_q, div_q;
  logic [W:0] trial;
  assign trial = {rem_q, quot_q[W-1]} - {1'b0, div_q};
  assign quot_o = {quot_q[W-2:0], ~trial[W]};
  assign rem_o = trial[W] ? {rem_q[W-2:0], quot_q[W-1]} : trial[W-1:0];
  assign last_o = state_q == DIV_BUSY && cnt_q == CW'(W-1);
  assign done_o = state_q == DIV_DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q <= '0;
      quot_q <= '0;
      rem_q <= '0;
      div_q <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: if (start_i) begin
          state_q <= DIV_BUSY;
          cnt_q <= '0;
          quot_q <= dividend_i;
          rem_q <= '0;
          div_q <= divisor_i;
        end
        DIV_BUSY: begin
          quot_q <= quot_o;
          rem_q <= rem_o;
          cnt_q <= cnt_q + 1'b1;
          if (last_o) state_q <= DIV_DONE;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage - ALU, branch resolve, HI/LO, single-cycle mult.
// Iterative divider and its stall path are built only when PCPU_EX_DIV_EN is defined.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ALU_OP_WIDTH-1:0] ex_alu_op,
  input  logic [31:0]             ex_alu_opa,
  input  logic [31:0]             ex_alu_opb,
  input  logic [BRANCH_WIDTH-1:0] ex_branch_type,
  input  logic [31:0]             ex_branch_tgt,
  input  logic                    ex_mem_re,
  input  logic                    ex_mem_we,
  input  logic                    ex_rf_we,
  output logic [31:0]             alu_out,
  output logic                    mem_re_o,
  output logic                    mem_we_o,
  output logic                    rf_we_o,
  output logic                    ex_stall,
  output logic                    br_taken,
  output logic [31:0]             br_target,
  output logic [31:0]             hi,
  output logic [31:0]             lo
);
  if (DIV_STEPS != 32) begin : g_steps_chk
    $error("DIV_STEPS must equal the 32-bit operand width");
  end
  logic [31:0] a, b, hi_q, lo_q, hi_d, lo_d;
  logic [63:0] prod;
  logic is_mult, signed_op;
  assign a = ex_alu_opa;
  assign b = ex_alu_opb;
  assign is_mult = ex_alu_op == OP_MULT || ex_alu_op == OP_MULTU;
  assign signed_op = ex_alu_op == OP_MULT || ex_alu_op == OP_DIV;
  // Sign-extending to 64 bits makes the low 64 product bits correct for signed and unsigned alike
  assign prod = {{32{signed_op & a[31]}}, a} * {{32{signed_op & b[31]}}, b};
`ifdef PCPU_EX_DIV_EN
  logic is_div, div_last, div_done, dz;
  logic [31:0] quot, rem, q_s, r_s;
  assign is_div = ex_alu_op == OP_DIV || ex_alu_op == OP_DIVU;
  ex_divider #(.W(DIV_STEPS)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start_i   (is_div),
    .dividend_i(mag(a, signed_op)),
    .divisor_i (mag(b, signed_op)),
    .last_o    (div_last),
    .done_o    (div_done),
    .quot_o    (quot),
    .rem_o     (rem)
  );
  // ID/EX holds the DIV operands for the whole stall, so signs are read live
  assign dz = b == '0;
  assign q_s = (signed_op && (a[31] ^ b[31])) ? -quot : quot;
  assign r_s = (signed_op && a[31]) ? -rem : rem;
  assign ex_stall = is_div && !div_done && !rst;
  assign hi_d = is_mult ? prod[63:32] : div_last ? (dz ? a : r_s) : hi_q;
  assign lo_d = is_mult ? prod[31:0] : div_last ? (dz ? 32'hFFFF_FFFF : q_s) : lo_q;
`else
  assign ex_stall = 1'b0;
  assign hi_d = is_mult ? prod[63:32] : hi_q;
  assign lo_d = is_mult ? prod[31:0] : lo_q;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  always_comb begin
    alu_out = '0;
    case (ex_alu_op)
      OP_ADD:  alu_out = a + b;
      OP_SUB:  alu_out = a - b;
      OP_AND:  alu_out = a & b;
      OP_OR:   alu_out = a | b;
      OP_XOR:  alu_out = a ^ b;
      OP_NOR:  alu_out = ~(a | b);
      OP_SLT:  alu_out = {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: alu_out = {31'b0, a < b};
      OP_SLL:  alu_out = b << a[4:0];
      OP_SRL:  alu_out = b >> a[4:0];
      OP_SRA:  alu_out = $signed(b) >>> a[4:0];
      OP_LUI:  alu_out = {b[15:0], 16'h0};
      OP_MFHI: alu_out = hi_q;
      OP_MFLO: alu_out = lo_q;
      default: alu_out = '0;
    endcase
  end
  assign br_taken = !ex_stall && (ex_branch_type == BR_EQ ? a == b :
                                  ex_branch_type == BR_NE ? a != b :
                                  ex_branch_type == BR_J);
  assign br_target = ex_branch_tgt;
  assign mem_re_o = ex_mem_re & ~ex_stall;
  assign mem_we_o = ex_mem_we & ~ex_stall;
  assign rf_we_o = ex_rf_we & ~ex_stall;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule
